dmi_dtm_core: RTL

Parametrised single-clock DTM register engine that sits between a JTAG TAP controller and the DMI CDC. It holds DTMCS and the DMI data register (capture/shift/update), and runs the DMI request/response FSM with sticky error reporting. Compared with the current DTM, it adds configurable address width, automatic retry on DMI_BUSY responses, and an optional response timeout.

---
 rtl/dm_pkg.sv | 62 ++++++
 rtl/dmi_dtm_core_if.sv | 33 +++
 rtl/dmi_dtm_shreg.sv | 37 +++
 rtl/dmi_dtm_core.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_pkg
//  Description : Shared debug-module types: DMI error/op/response encodings,
//                DTMCS layout and fixed read-data markers.
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int unsigned c_ABITS_W = 6;

    typedef enum logic [1:0] {
        DMI_NO_ERROR  = 2'd0,
        DMI_RESERVED  = 2'd1,
        DMI_OP_FAILED = 2'd2,
        DMI_BUSY      = 2'd3
    } dmi_error_e;

    typedef enum logic [1:0] {
        DTM_NOP     = 2'd0,
        DTM_READ    = 2'd1,
        DTM_WRITE   = 2'd2,
        DTM_OP_RSVD = 2'd3
    } dtm_op_e;

    typedef enum logic [1:0] {
        DTM_RESP_SUCCESS = 2'd0,
        DTM_RESP_RSVD    = 2'd1,
        DTM_RESP_ERR     = 2'd2,
        DTM_RESP_BUSY    = 2'd3
    } dtm_resp_e;

    typedef struct packed {
        logic [13:0]          zero1;
        logic                 dmihardreset;
        logic                 dmireset;
        logic                 zero0;
        logic [2:0]           idle;
        dmi_error_e           dmistat;
        logic [c_ABITS_W-1:0] abits;
        logic [3:0]           version;
    } dtmcs_t;

    localparam logic [31:0] c_DATA_OP_FAILED = 32'hDEAD_BEEF;
    localparam logic [31:0] c_DATA_BUSY      = 32'hB051_B051;
    localparam logic [31:0] c_DATA_RESP_RSVD = 32'hBAAD_C0DE;
    localparam logic [3:0]  c_DTM_VERSION    = 4'd1;

    function automatic dtmcs_t dtmcs_capture(input logic [2:0]           idle,
                                             input dmi_error_e           stat,
                                             input logic [c_ABITS_W-1:0] abits);
        dtmcs_t v;
        v              = '0;
        v.idle         = idle;
        v.dmistat      = stat;
        v.abits        = abits;
        v.version      = c_DTM_VERSION;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmi_dtm_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_dtm_core_if
//  Description : DMI request/response channel between the DTM and the CDC.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmi_dtm_core_if #(
    parameter int unsigned ADDR_WIDTH = 7
);
    import dm_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    dtm_op_e               req_op;
    logic [31:0]           req_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    dtm_resp_e             resp_resp;

    modport master (
        output req_valid, req_addr, req_op, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_resp
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_resp
    );

endinterface
`default_nettype wire

// File: rtl/dmi_dtm_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_dtm_shreg
//  Description : Generic JTAG data register: parallel capture, LSB-first shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmi_dtm_shreg #(
    parameter int unsigned WIDTH = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             clear_i,
    input  wire logic             capture_i,
    input  wire logic             shift_i,
    input  wire logic [WIDTH-1:0] capture_data_i,
    input  wire logic             tdi_i,
    output logic      [WIDTH-1:0] q_o,
    output logic                  tdo_o
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_q <= '0;
        end else if (capture_i) begin
            r_q <= capture_data_i;
        end else if (shift_i) begin
            r_q <= {tdi_i, r_q[WIDTH-1:1]};
        end
    end

    assign q_o   = r_q;
    assign tdo_o = r_q[0];

endmodule
`default_nettype wire

// File: rtl/dmi_dtm_core.sv
`default_nettype none
// ============================================================================
//  Module      : dmi_dtm_core
//  Description : DTM register engine: DTMCS, DMI DR and the DMI request/response
//                FSM with busy retry and sticky error. Optional response
//                timeout enabled by defining DMI_DTM_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmi_dtm_core
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned IDLE_HINT      = 1,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        clear_i,
    input  wire logic        capture_i,
    input  wire logic        shift_i,
    input  wire logic        update_i,
    input  wire logic        tdi_i,
    input  wire logic        dtmcs_select_i,
    input  wire logic        dmi_select_i,
    output logic             dtmcs_tdo_o,
    output logic             dmi_tdo_o,
    dmi_dtm_core_if.master   dmi,
    output logic             dmi_hard_reset_o,
    output logic [1:0]       dmistat_o
);

    localparam int unsigned c_DR_W    = ADDR_WIDTH + 34;
    localparam int unsigned c_RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_DRAIN     = 2'd3
    } state_e;

    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 32 || IDLE_HINT > 7 || TIMEOUT_CYCLES < 1)
    begin : g_param_check
        $error("dmi_dtm_core: illegal parameter value");
    end

    state_e                r_state, w_state_d;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_d;
    logic [31:0]           r_data,  w_data_d;
    dtm_op_e               r_op,    w_op_d;
    dmi_error_e            r_error, w_error_d;
    logic [c_RETRY_W-1:0]  r_retry, w_retry_d;
    logic                  r_hard_reset;

    logic [31:0]           w_dtmcs_q;
    logic [29:0]           w_dtmcs_unused;
    logic [31:0]           w_dtmcs_capture;
    logic [c_DR_W-1:0]     w_dr_q;
    logic [c_DR_W-1:0]     w_dr_capture;
    logic                  w_dtmcs_upd, w_dmi_upd;
    logic                  w_hard_reset_req, w_dmireset, w_soft_clear;
    logic                  w_read_busy, w_busy_evt;
    logic                  w_set_opf, w_set_busy;
    logic                  w_timeout;
    dmi_error_e            w_capture_stat;

    assign w_dtmcs_upd      = update_i & dtmcs_select_i;
    assign w_dmi_upd        = update_i & dmi_select_i;
    assign w_hard_reset_req = w_dtmcs_upd & w_dtmcs_q[17];
    assign w_dmireset       = w_dtmcs_upd & w_dtmcs_q[16];
    assign w_soft_clear     = clear_i | w_hard_reset_req;
    assign w_dtmcs_unused   = {w_dtmcs_q[31:18], w_dtmcs_q[15:0]};

    assign w_read_busy = ((r_state == S_REQ) || (r_state == S_WAIT_RESP)) && (r_op == DTM_READ);
    assign w_busy_evt  = (update_i & (dtmcs_select_i | dmi_select_i) & (r_state != S_IDLE))
                       | (capture_i & dmi_select_i & w_read_busy);

    assign w_capture_stat  = w_busy_evt ? DMI_BUSY : r_error;
    assign w_dtmcs_capture = dtmcs_capture(3'(IDLE_HINT), r_error, c_ABITS_W'(ADDR_WIDTH));
    assign w_dr_capture    = {r_addr, r_data, w_capture_stat};

    dmi_dtm_shreg #(.WIDTH(32)) u_dtmcs_shreg (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (w_soft_clear),
        .capture_i      (capture_i & dtmcs_select_i),
        .shift_i        (shift_i & dtmcs_select_i),
        .capture_data_i (w_dtmcs_capture),
        .tdi_i          (tdi_i),
        .q_o            (w_dtmcs_q),
        .tdo_o          (dtmcs_tdo_o)
    );

    dmi_dtm_shreg #(.WIDTH(c_DR_W)) u_dmi_shreg (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (w_soft_clear),
        .capture_i      (capture_i & dmi_select_i),
        .shift_i        (shift_i & dmi_select_i),
        .capture_data_i (w_dr_capture),
        .tdi_i          (tdi_i),
        .q_o            (w_dr_q),
        .tdo_o          (dmi_tdo_o)
    );

`ifdef DMI_DTM_TIMEOUT_EN
    localparam int unsigned c_TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [c_TCNT_W-1:0] r_tcnt;

    assign w_timeout = (r_state == S_WAIT_RESP) && !dmi.resp_valid
                    && (r_tcnt == c_TCNT_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive WaitResp cycles; a retry re-enters via Req and restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_soft_clear) begin
            r_tcnt <= '0;
        end else if ((r_state == S_WAIT_RESP) && (w_state_d == S_WAIT_RESP)) begin
            r_tcnt <= r_tcnt + 1'b1;
        end else begin
            r_tcnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_d      = r_state;
        w_addr_d       = r_addr;
        w_data_d       = r_data;
        w_op_d         = r_op;
        w_retry_d      = r_retry;
        w_set_opf      = 1'b0;
        w_set_busy     = w_busy_evt;
        dmi.req_valid  = 1'b0;
        dmi.resp_ready = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_dmi_upd && (r_error == DMI_NO_ERROR)) begin
                    w_addr_d = w_dr_q[c_DR_W-1:34];
                    w_data_d = w_dr_q[33:2];
                    w_op_d   = dtm_op_e'(w_dr_q[1:0]);
                    if ((w_op_d == DTM_READ) || (w_op_d == DTM_WRITE)) begin
                        w_state_d = S_REQ;
                        w_retry_d = '0;
                    end
                end
            end
            S_REQ: begin
                dmi.req_valid = 1'b1;
                if (dmi.req_ready) begin
                    w_state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                dmi.resp_ready = 1'b1;
                if (dmi.resp_valid) begin
                    w_state_d = S_IDLE;
                    case (dmi.resp_resp)
                        DTM_RESP_SUCCESS: begin
                            if (r_op == DTM_READ) w_data_d = dmi.resp_data;
                        end
                        DTM_RESP_ERR: begin
                            w_set_opf = 1'b1;
                            if (r_op == DTM_READ) w_data_d = c_DATA_OP_FAILED;
                        end
                        DTM_RESP_BUSY: begin
                            if (r_retry < c_RETRY_W'(MAX_RETRIES)) begin
                                w_retry_d = r_retry + 1'b1;
                                w_state_d = S_REQ;
                            end else begin
                                w_set_busy = 1'b1;
                                w_data_d   = c_DATA_BUSY;
                            end
                        end
                        default: begin
                            w_data_d = c_DATA_RESP_RSVD;
                        end
                    endcase
                end else if (w_timeout) begin
                    w_set_opf = 1'b1;
                    if (r_op == DTM_READ) w_data_d = c_DATA_OP_FAILED;
                    w_state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                dmi.resp_ready = 1'b1;
                if (dmi.resp_valid) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // First error is sticky; dmireset clears it even against a new error.
        w_error_d = r_error;
        if (r_error == DMI_NO_ERROR) begin
            if (w_set_opf) begin
                w_error_d = DMI_OP_FAILED;
            end else if (w_set_busy) begin
                w_error_d = DMI_BUSY;
            end
        end
        if (w_dmireset) begin
            w_error_d = DMI_NO_ERROR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_soft_clear) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_op    <= DTM_NOP;
            r_error <= DMI_NO_ERROR;
            r_retry <= '0;
        end else begin
            r_state <= w_state_d;
            r_addr  <= w_addr_d;
            r_data  <= w_data_d;
            r_op    <= w_op_d;
            r_error <= w_error_d;
            r_retry <= w_retry_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hard_reset <= 1'b0;
        end else begin
            r_hard_reset <= w_hard_reset_req & ~clear_i;
        end
    end

    assign dmi.req_addr     = r_addr;
    assign dmi.req_op       = r_op;
    assign dmi.req_data     = r_data;
    assign dmi_hard_reset_o = r_hard_reset;
    assign dmistat_o        = r_error;

endmodule
`default_nettype wire
